// File: rtl/axi_spi_master.sv
// AXI-lite SPI master: CPOL/CPHA engine, SCLK divider, TX/RX FIFOs, chip selects, sticky overflow.
// Optional internal MOSI->MISO loopback via CTRL[4] when AXI_SPI_LOOPBACK_EN is defined.
module axi_spi_master #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_CS     = 1,
  parameter int unsigned DIV_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [11:0]       s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [11:0]       s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned ECW = $clog2(2 * DATA_W + 1);
  localparam logic [ECW-1:0] LastEdge = ECW'(2 * DATA_W - 1);
`ifdef AXI_SPI_LOOPBACK_EN
  localparam logic LoopbackEn = 1'b1;
`else
  localparam logic LoopbackEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;
  state_e state;

  logic              enable, cpol, cpha, lsb_first, loopback, overflow;
  logic [2:0]        cs_idx;
  logic [DIV_W-1:0]  div, div_cnt;
  logic [ECW-1:0]    edge_cnt;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]       tx_wp, tx_rp, rx_wp, rx_rp;

  logic tx_empty, tx_full, rx_empty, rx_full, busy, tick, rx_bit;
  logic wr_hs, rd_hs, ovf_clr;
  logic [2:0] wsel, rsel;
  logic unused_bits;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign busy     = (state != StIdle);
  assign tick     = busy && (div_cnt >= div);
  assign rx_bit   = loopback ? spi_mosi : spi_miso;

  // Register select; anything outside the first 32 bytes decodes as unmapped (7).
  assign wsel    = (s_axi_awaddr[11:5] == 7'd0) ? s_axi_awaddr[4:2] : 3'd7;
  assign rsel    = (s_axi_araddr[11:5] == 7'd0) ? s_axi_araddr[4:2] : 3'd7;
  assign wr_hs   = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
  assign rd_hs   = s_axi_arready && s_axi_arvalid;
  assign ovf_clr = wr_hs && (wsel == 3'd4) && s_axi_wdata[5];
  assign unused_bits = ^{s_axi_wstrb, s_axi_wdata, s_axi_awaddr, s_axi_araddr};

  function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] v, input logic b,
                                                 input logic lsb);
    return lsb ? ((v >> 1) | (DATA_W'(b) << (DATA_W - 1))) : ((v << 1) | DATA_W'(b));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= 2'b00;
      s_axi_rdata   <= 32'd0;
      enable        <= 1'b0;
      cpol          <= 1'b0;
      cpha          <= 1'b0;
      lsb_first     <= 1'b0;
      loopback      <= 1'b0;
      cs_idx        <= 3'd0;
      div           <= '0;
      tx_wp         <= '0;
      rx_rp         <= '0;
    end else begin
      s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
      s_axi_wready  <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
      s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;

      if (wr_hs) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= (wsel == 3'd2 && tx_full) ? 2'b10 : 2'b00;
        case (wsel)
          3'd0: begin
            enable    <= s_axi_wdata[0];
            cpol      <= s_axi_wdata[1];
            cpha      <= s_axi_wdata[2];
            lsb_first <= s_axi_wdata[3];
            loopback  <= s_axi_wdata[4] & LoopbackEn;
            cs_idx    <= s_axi_wdata[10:8];
          end
          3'd1: div <= s_axi_wdata[DIV_W-1:0];
          3'd2: begin
            if (!tx_full) begin
              tx_mem[tx_wp[AW-1:0]] <= s_axi_wdata[DATA_W-1:0];
              tx_wp <= tx_wp + 1'b1;
            end
          end
          default: ;
        endcase
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end

      if (rd_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rresp  <= 2'b00;
        case (rsel)
          3'd0: s_axi_rdata <= {21'd0, cs_idx, 3'd0, loopback, lsb_first, cpha, cpol, enable};
          3'd1: s_axi_rdata <= 32'(div);
          3'd2: s_axi_rdata <= 32'd0;
          3'd3: begin
            if (rx_empty) begin
              s_axi_rdata <= 32'd0;
              s_axi_rresp <= 2'b10;
            end else begin
              s_axi_rdata <= 32'(rx_mem[rx_rp[AW-1:0]]);
              rx_rp <= rx_rp + 1'b1;
            end
          end
          3'd4: s_axi_rdata <= 32'({overflow, rx_empty, rx_full, tx_empty, tx_full, busy});
          default: s_axi_rdata <= 32'hDEAD_BEEF;
        endcase
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdle;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= '1;
      tx_rp    <= '0;
      rx_wp    <= '0;
      overflow <= 1'b0;
    end else begin
      // >= rather than == so a DIV shrink mid-transfer cannot stall the divider.
      if (!busy || tick) div_cnt <= '0;
      else div_cnt <= div_cnt + 1'b1;
      if (ovf_clr) overflow <= 1'b0;

      unique case (state)
        StIdle: begin
          spi_sclk <= cpol;
          if (enable && !tx_empty) begin
            tx_sh    <= tx_mem[tx_rp[AW-1:0]];
            spi_mosi <= out_bit(tx_mem[tx_rp[AW-1:0]], lsb_first);
            tx_rp    <= tx_rp + 1'b1;
            rx_sh    <= '0;
            edge_cnt <= '0;
            spi_cs_n <= ~(NUM_CS'(1) << cs_idx);
            state    <= StSetup;
          end
        end
        StSetup: if (tick) state <= StShift;
        StShift: begin
          if (tick) begin
            spi_sclk <= ~spi_sclk;
            edge_cnt <= edge_cnt + 1'b1;
            // Even count = leading edge of the bit cell, odd = trailing.
            if (edge_cnt[0] == cpha) begin
              rx_sh <= shift_rx(rx_sh, rx_bit, lsb_first);
            end else if (cpha) begin
              spi_mosi <= out_bit(tx_sh, lsb_first);
              tx_sh    <= shift_tx(tx_sh, lsb_first);
            end else begin
              spi_mosi <= out_bit(shift_tx(tx_sh, lsb_first), lsb_first);
              tx_sh    <= shift_tx(tx_sh, lsb_first);
            end
            if (edge_cnt == LastEdge) state <= StHold;
          end
        end
        StHold: begin
          if (tick) begin
            spi_cs_n <= '1;
            state    <= StIdle;
            if (rx_full) begin
              overflow <= 1'b1;
            end else begin
              rx_mem[rx_wp[AW-1:0]] <= rx_sh;
              rx_wp <= rx_wp + 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule

// File: doc/axi_spi_master.md
Name: axi_spi_master

Overview:
- Parametrised AXI-lite SPI master, successor to the register-only SPI stub. Real serial engine with CPOL/CPHA modes, programmable SCLK divider, TX/RX FIFOs, multiple chip selects and sticky status.
- Sits on the SoC AXI-lite peripheral bus behind the PicoRV32 interconnect. Drives external SPI pads.

Parameters:
- DATA_W, 8, SPI word width in bits (1..32); FIFO entries are DATA_W wide, right-aligned in 32-bit registers.
- FIFO_DEPTH, 4, TX and RX FIFO depth; power of two, >= 2.
- NUM_CS, 1, number of active-low chip-select outputs (1..8).
- DIV_W, 16, width of the clock-divider register.

Ports:
- clk  in  1  system clock
- reset  in  1  reset; one clock, reset is synchronous and active-high
- s_axi_awaddr  in  12  write address
- s_axi_awvalid  in  1  / s_axi_awready out 1: AW handshake
- s_axi_wdata  in  32  / s_axi_wstrb in 4 (ignored; full-word writes) / s_axi_wvalid in 1 / s_axi_wready out 1
- s_axi_bresp  out  2  / s_axi_bvalid out 1 / s_axi_bready in 1
- s_axi_araddr  in  12  / s_axi_arvalid in 1 / s_axi_arready out 1
- s_axi_rdata  out  32  / s_axi_rresp out 2 / s_axi_rvalid out 1 / s_axi_rready in 1
- spi_sclk  out  1  serial clock
- spi_mosi  out  1  master out
- spi_miso  in  1  master in; sampled directly, no synchroniser
- spi_cs_n  out  NUM_CS  active-low chip selects

Behaviour:
- Reset: all AXI ready/valid low, bresp/rresp 0, rdata 0, spi_sclk = 0, spi_mosi = 0, spi_cs_n all 1. CTRL = 0, DIV = 0, FIFOs empty, overflow flag 0, FSM IDLE.
- Register map (addr[4:0]):
  - 0x00 CTRL RW: [0] enable, [1] cpol, [2] cpha, [3] lsb_first, [4] loopback (optional feature), [10:8] cs index.
  - 0x04 DIV RW: [DIV_W-1:0]. SCLK half-period = DIV+1 clk cycles.
  - 0x08 TXDATA WO: push wdata[DATA_W-1:0].
  - 0x0C RXDATA RO: pop; rdata = zero-extended word.
  - 0x10 STATUS: [0] busy, [1] tx_full, [2] tx_empty, [3] rx_full, [4] rx_empty, [5] rx_overflow. Bit 5 is sticky; writing 1 to it clears it.
  - Other addresses: reads return 0xDEADBEEF with OKAY; writes are ignored with OKAY.
- AXI write handshake:
  - A write is accepted when awvalid and wvalid are both high and bvalid is low. awready and wready pulse high together for one cycle. bvalid rises on the next cycle and holds until bready.
  - Latency is 1 cycle from accept to bvalid. No outstanding-transaction overlap.
- AXI read handshake:
  - arready pulses one cycle when arvalid is high and rvalid is low. rvalid rises the next cycle, with rdata registered, and holds until rready.
  - The RX pop occurs at the arready cycle.
- Error cases:
  - Write to TXDATA when the TX FIFO is full: data dropped, bresp = SLVERR (2'b10).
  - Read of RXDATA when the RX FIFO is empty: rdata = 0, rresp = SLVERR, no pop.
- Engine FSM: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> IDLE.
  - IDLE: when enable=1 and TX not empty, pop a word into the shift register, drive cs_n[cs index] low (cs index >= NUM_CS selects none), go to CS_SETUP.
  - CS_SETUP: lasts one half-period. SCLK idles at cpol.
  - SHIFT: 2*DATA_W half-periods, with SCLK toggling at each half-period boundary. With cpha=0, MOSI is valid at CS_SETUP entry, MISO is sampled on the leading edge and MOSI shifts on the trailing edge. With cpha=1, MOSI shifts on the leading edge and MISO is sampled on the trailing edge. Bit order is MSB-first unless lsb_first=1.
  - CS_HOLD: lasts one half-period, then cs_n returns high. The received word is pushed to RX here.
  - busy = (state != IDLE).
- RX full at push: word discarded, rx_overflow set.
- Simultaneous events: a push and pop on the same cycle in either FIFO are both honoured; count is unchanged. Clearing rx_overflow on the same cycle as a new overflow leaves it set.
- CTRL/DIV writes take effect immediately, including mid-transfer. Software must only change mode while busy=0; behaviour otherwise is unspecified but must not hang the FSM.
- Clearing enable mid-transfer completes the current word, then the FSM stays in IDLE.
- Reset mid-transfer: immediate return to reset values; FIFO contents are lost.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full means the MSBs differ and the rest are equal.

Optional Feature:
- Macro: AXI_SPI_LOOPBACK_EN.
- Defined: CTRL[4]=1 internally routes spi_mosi to the receive sampler in place of spi_miso.
- Undefined: CTRL[4] reads 0, writes to it are ignored, and spi_miso is always used.

Test Plan:
- Reset, then read 0x10 -> 0x0000_0014 (tx_empty, rx_empty). Read 0x00 -> 0. Read 0x20 -> 0xDEADBEEF, OKAY.
- Mode 0, DIV=1, loopback on: write 0xA5 to TXDATA -> 8 SCLK pulses, each half-period 2 clk, MOSI bits 1,0,1,0,0,1,0,1. Then RXDATA reads 0xA5 and busy returns to 0.
- Mode 3 (cpol=1, cpha=1), lsb_first=1, external MISO driven 0x3C LSB-first -> SCLK idles high, RXDATA = 0x3C, cs_n[0] low only during the transfer.
- enable=0: push 5 words with FIFO_DEPTH=4 -> 5th write returns SLVERR, tx_full=1. Set enable -> 4 transfers complete back to back.
- With 4 words pending in RX, complete a 5th transfer -> rx_overflow=1. Write 0x20 to 0x10 -> flag cleared. A 5th RX read on empty -> SLVERR, rdata 0.
- Assert reset during SHIFT -> the next cycle has cs_n all 1, sclk=0, busy=0 and both FIFOs empty.
